// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types: address word, cache line, arbiter side.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cline;

    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } lc3b_arb_side;

endpackage

// File: rtl/l2_arbiter.sv
// Round-robin arbiter between the I/D L1 caches and l2_cache_control; grant lands 1 cycle after request.
// The granted request is latched and held until l2_resp, then a 1-cycle RELEASE gap precedes the next grant.
module l2_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp,
    output logic [15:0]       conflict_count
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RELEASE
    } state_t;

    state_t            state, state_nxt;
    lc3b_arb_side      last_grant;
    lc3b_arb_side      grant_side;
    logic              grant;
    logic              i_req, d_req;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [LINE_W-1:0] lat_wdata;

    // Read and write together is a malformed D request and is ignored.
    assign i_req = i_read;
    assign d_req = d_read ^ d_write;

    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        grant_side = ARB_I;
        l2_read    = 1'b0;
        l2_write   = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && (!d_req || last_grant == ARB_D)) begin
                    grant      = 1'b1;
                    grant_side = ARB_I;
                    state_nxt  = SERVE_I;
                end else if (d_req) begin
                    grant      = 1'b1;
                    grant_side = ARB_D;
                    state_nxt  = SERVE_D;
                end
            end
            SERVE_I: begin
                l2_read  = ~lat_write;
                l2_write = lat_write;
                i_resp   = l2_resp;
                if (l2_resp) state_nxt = RELEASE;
            end
            SERVE_D: begin
                l2_read  = ~lat_write;
                l2_write = lat_write;
                d_resp   = l2_resp;
                if (l2_resp) state_nxt = RELEASE;
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= ARB_D;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                if (grant_side == ARB_I) begin
                    lat_write <= 1'b0;
                    lat_addr  <= i_address;
                    lat_wdata <= '0;
                end else begin
                    lat_write <= d_write;
                    lat_addr  <= d_address;
                    lat_wdata <= d_wdata;
                end
            end
            if (l2_resp && state == SERVE_I) last_grant <= ARB_I;
            if (l2_resp && state == SERVE_D) last_grant <= ARB_D;
        end
    end

    // Counts contention in every state, not only when a grant decision is made.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_count <= 16'h0000;
        end else if (i_req && d_req && conflict_count != 16'hFFFF) begin
            conflict_count <= conflict_count + 16'h0001;
        end
    end

    assign l2_address = lat_addr;
    assign l2_wdata   = lat_wdata;
    assign i_rdata    = l2_rdata;
    assign d_rdata    = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Randomised scoreboard bench for l2_arbiter with an L2 responder model and a transaction-level reference.
module tb_l2_arbiter;
    import lc3b_types::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         i_read = 1'b0;
    logic [15:0]  i_address = '0;
    logic [127:0] i_rdata;
    logic         i_resp;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [15:0]  d_address = '0;
    logic [127:0] d_wdata = '0;
    logic [127:0] d_rdata;
    logic         d_resp;
    logic         l2_read;
    logic         l2_write;
    logic [15:0]  l2_address;
    logic [127:0] l2_wdata;
    logic [127:0] l2_rdata = '0;
    logic         l2_resp = 1'b0;
    logic [15:0]  conflict_count;

    l2_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata), .l2_resp(l2_resp), .conflict_count(conflict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        lc3b_arb_side side;
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
    } exp_t;

    exp_t         exp_q[$];
    int           vectors = 0;
    int           miscompares = 0;
    lc3b_arb_side model_last = ARB_D;
    logic [15:0]  model_cc = '0;
    bit           l2_en = 1'b1;
    bit           inject_resp = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Contention reference: a cycle counts when I reads and D has exactly one of read/write.
    always @(posedge clk or posedge reset) begin
        if (reset) model_cc = '0;
        else if (i_read && (d_read ^ d_write) && model_cc != 16'hFFFF) model_cc = model_cc + 16'd1;
    end

    // L2 responder: answers each request after 0..3 extra cycles with a one-cycle resp pulse.
    initial begin : l2_model
        bit armed = 1'b0;
        int ctr = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!l2_en) begin
                armed   = 1'b0;
                l2_resp = inject_resp;
            end else if (l2_resp) begin
                l2_resp = 1'b0;
                armed   = 1'b0;
            end else if (l2_read || l2_write) begin
                if (!armed) begin
                    armed = 1'b1;
                    ctr   = $urandom_range(0, 3);
                end
                if (ctr == 0) begin
                    l2_resp  = 1'b1;
                    l2_rdata = rand128();
                end else begin
                    ctr--;
                end
            end
        end
    end

    // Monitor: pops the expected transaction when L2 activity starts and checks it every cycle.
    initial begin : monitor
        bit          prev_act = 1'b0;
        bit          have_cur = 1'b0;
        bit          act;
        exp_t        cur;
        logic [15:0] last_addr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_act  = 1'b0;
                have_cur  = 1'b0;
                last_addr = '0;
                continue;
            end
            act = l2_read | l2_write;
            if (act && !prev_act) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    have_cur = 1'b0;
                    $display("FAIL unexpected_l2_request: got addr %h with empty scoreboard at %0t", l2_address, $time);
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                end
            end
            if (act && have_cur) begin
                chk("l2_write_op", {127'd0, l2_write}, {127'd0, cur.wr});
                chk("l2_read_op", {127'd0, l2_read}, {127'd0, !cur.wr});
                chk("l2_address", {112'd0, l2_address}, {112'd0, cur.addr});
                if (cur.wr) chk("l2_wdata", l2_wdata, cur.wdata);
                last_addr = cur.addr;
            end
            if (!act) chk("idle_address_hold", {112'd0, l2_address}, {112'd0, last_addr});
            chk("i_resp", {127'd0, i_resp},
                {127'd0, act && have_cur && cur.side == ARB_I && l2_resp});
            chk("d_resp", {127'd0, d_resp},
                {127'd0, act && have_cur && cur.side == ARB_D && l2_resp});
            if (i_resp) chk("i_rdata", i_rdata, l2_rdata);
            if (d_resp) chk("d_rdata", d_rdata, l2_rdata);
            chk("conflict_count", {112'd0, conflict_count}, {112'd0, model_cc});
            prev_act = act;
        end
    end

    // dmode: 0 none, 1 read, 2 write-back, 3 read+write together (not a request).
    task automatic run_txn(input bit use_i, input int dmode, input logic [15:0] ia,
                           input logic [15:0] da, input logic [127:0] dd);
        bit           dv;
        exp_t         e_i, e_d;
        lc3b_arb_side order[2];
        int           n, cur, gap;
        bit           seen2, act, got;
        dv = (dmode == 1 || dmode == 2);
        @(negedge clk);
        i_read    = use_i;
        i_address = ia;
        d_read    = (dmode == 1 || dmode == 3);
        d_write   = (dmode == 2 || dmode == 3);
        d_address = da;
        d_wdata   = dd;
        e_i = '{side: ARB_I, wr: 1'b0, addr: ia, wdata: '0};
        e_d = '{side: ARB_D, wr: (dmode == 2), addr: da, wdata: dd};
        n = 0;
        if (use_i && dv) begin
            order[0] = (model_last == ARB_D) ? ARB_I : ARB_D;
            order[1] = (order[0] == ARB_I) ? ARB_D : ARB_I;
            n = 2;
        end else if (use_i) begin
            order[0] = ARB_I;
            n = 1;
        end else if (dv) begin
            order[0] = ARB_D;
            n = 1;
        end
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(order[k] == ARB_I ? e_i : e_d);
            model_last = order[k];
        end
        @(negedge clk);
        chk("grant_latency", {127'd0, l2_read | l2_write}, {127'd0, n > 0});
        if (n == 0) begin
            repeat (3) begin
                @(negedge clk);
                chk("no_grant", {126'd0, l2_read, l2_write}, 128'd0);
            end
        end else begin
            cur = 0;
            gap = 0;
            seen2 = 1'b0;
            for (int cyc = 0; cyc < 200 && cur < n; cyc++) begin
                if (cyc > 0) @(negedge clk);
                act = l2_read | l2_write;
                if (cur == 1 && !seen2) begin
                    if (act) begin
                        seen2 = 1'b1;
                        chk("release_gap", 128'(gap), 128'd2);
                    end else begin
                        gap++;
                    end
                end
                got = (order[cur] == ARB_I) ? i_resp : d_resp;
                if (got) begin
                    if (order[cur] == ARB_I) i_read = 1'b0;
                    else begin
                        d_read  = 1'b0;
                        d_write = 1'b0;
                    end
                    cur++;
                end else if (act) begin
                    // The served side's inputs may wander; the latched request must not.
                    if (order[cur] == ARB_I) i_address = $urandom;
                    else begin
                        d_address = $urandom;
                        d_wdata   = rand128();
                    end
                end
            end
            if (cur < n) begin
                vectors++;
                miscompares++;
                $display("FAIL txn_timeout: got %0d responses expected %0d", cur, n);
            end
        end
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin : driver
        lc3b_arb_side first;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_l2_read", {127'd0, l2_read}, 128'd0);
        chk("rst_l2_write", {127'd0, l2_write}, 128'd0);
        chk("rst_resp", {126'd0, i_resp, d_resp}, 128'd0);
        chk("rst_conflict", {112'd0, conflict_count}, 128'd0);
        chk("rst_l2_address", {112'd0, l2_address}, 128'd0);
        chk("rst_l2_wdata", l2_wdata, 128'd0);
        #2 reset = 1'b0;

        run_txn(1'b1, 0, 16'h1230, 16'h0000, '0);
        run_txn(1'b1, 1, $urandom, $urandom, rand128());
        run_txn(1'b1, 1, $urandom, $urandom, rand128());
        run_txn(1'b0, 2, 16'h0000, 16'hBEE0, {16{8'hA5}});
        run_txn(1'b0, 3, 16'h0000, $urandom, rand128());

        // Stray L2 response while idle must be ignored.
        l2_en = 1'b0;
        @(negedge clk);
        inject_resp = 1'b1;
        @(negedge clk);
        inject_resp = 1'b0;
        chk("stray_resp_i", {127'd0, i_resp}, 128'd0);
        chk("stray_resp_d", {127'd0, d_resp}, 128'd0);
        @(negedge clk);
        @(negedge clk);
        l2_en = 1'b1;
        run_txn(1'b1, 0, $urandom, 16'h0000, '0);

        for (int t = 0; t < 150; t++) begin
            run_txn($urandom % 2, int'($urandom % 4), $urandom, $urandom, rand128());
        end

        // Reset in the middle of a D write-back drops it silently.
        l2_en = 1'b0;
        @(negedge clk);
        d_write   = 1'b1;
        d_address = 16'h4C40;
        d_wdata   = rand128();
        exp_q.push_back('{side: ARB_D, wr: 1'b1, addr: 16'h4C40, wdata: d_wdata});
        repeat (3) @(negedge clk);
        chk("serve_d_active", {127'd0, l2_write}, 128'd1);
        #3 reset = 1'b1;
        #1;
        chk("rst_mid_l2_write", {127'd0, l2_write}, 128'd0);
        chk("rst_mid_d_resp", {127'd0, d_resp}, 128'd0);
        model_last = ARB_D;
        d_write = 1'b0;
        @(negedge clk);
        #3 reset = 1'b0;
        l2_en = 1'b1;
        run_txn(1'b1, 0, $urandom, 16'h0000, '0);

        // Hold both sides requesting long enough to saturate the contention counter.
        l2_en = 1'b0;
        @(negedge clk);
        i_read    = 1'b1;
        d_read    = 1'b1;
        i_address = $urandom;
        d_address = $urandom;
        first = (model_last == ARB_D) ? ARB_I : ARB_D;
        exp_q.push_back('{side: first, wr: 1'b0,
                          addr: (first == ARB_I) ? i_address : d_address, wdata: '0});
        repeat (70000) @(negedge clk);
        chk("conflict_saturated", {112'd0, conflict_count}, {112'd0, 16'hFFFF});
        i_read = 1'b0;
        d_read = 1'b0;
        #3 reset = 1'b1;
        @(negedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width (lc3b_word).
REQ-002 SHALL have parameter LINE_W, default 128, cache line width (lc3b_cline).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_read  input  1  I-cache line read request; I side is read-only.
REQ-006 i_address  input  ADDR_W  I-cache line address.
REQ-007 i_rdata  output  LINE_W  line returned to I-cache.
REQ-008 i_resp  output  1  I-cache completion strobe.
REQ-009 d_read, d_write  input  1 each  D-cache line read / write-back request.
REQ-010 d_address  input  ADDR_W  D-cache line address.
REQ-011 d_wdata  input  LINE_W  D-cache write-back line.
REQ-012 d_rdata  output  LINE_W  line returned to D-cache.
REQ-013 d_resp  output  1  D-cache completion strobe.
REQ-014 l2_read, l2_write  output  1 each  request to L2 cache controller.
REQ-015 l2_address  output  ADDR_W; l2_wdata  output  LINE_W  request payload to L2.
REQ-016 l2_rdata  input  LINE_W; l2_resp  input  1  L2 data and completion strobe.
REQ-017 conflict_count  output  16  saturating count of cycles in which both sides request.

Function
REQ-018 A side requests when: I = i_read; D = d_read XOR d_write. d_read and d_write high together SHALL be treated as no D request.
REQ-019 States: IDLE, SERVE_I, SERVE_D, RELEASE.
REQ-020 IDLE: one requester only -> grant it; both -> grant the side not recorded in last_grant; none -> stay in IDLE.
REQ-021 On a grant, op, address and wdata SHALL be latched and the state SHALL become SERVE_x on the next edge; arbitration latency is 1 cycle.
REQ-022 In SERVE_x, l2_read/l2_write/l2_address/l2_wdata SHALL be driven from the latches only and SHALL stay stable until l2_resp.
REQ-023 A requester deasserting during SERVE_x SHALL NOT abort the transaction; the arbiter SHALL hold the request until l2_resp.
REQ-024 x_resp SHALL equal l2_resp combinationally while in SERVE_x; the other side's resp SHALL be 0.
REQ-025 On l2_resp in SERVE_x: last_grant <= x; next state RELEASE.
REQ-026 RELEASE SHALL last exactly 1 cycle with l2_read = l2_write = 0 and both resp = 0, then go to IDLE. A fresh request is therefore granted 2 cycles after resp at the earliest.
REQ-027 i_rdata and d_rdata SHALL both be wired to l2_rdata; data is qualified only by the matching resp.
REQ-028 l2_resp outside SERVE_x SHALL be ignored.
REQ-029 conflict_count SHALL increment in every cycle where both sides request, in any state, and SHALL saturate at 16'hFFFF.
REQ-030 In IDLE and RELEASE, l2_address and l2_wdata SHALL hold their latched values; l2_read = l2_write = 0.

Reset
REQ-031 On reset the state SHALL become IDLE immediately, including from SERVE_x; any in-flight transaction is dropped with no resp.
REQ-032 Reset values SHALL be: last_grant = D (I wins the first tie); latches = 0; conflict_count = 0; l2_read = l2_write = i_resp = d_resp = 0.

Structure
REQ-033 lc3b_types SHALL hold lc3b_word, lc3b_cline and a new enum lc3b_arb_side {ARB_I, ARB_D}. The state enum SHALL be local to the module.
REQ-034 The block SHALL be a single module with no sub-modules. It SHALL sit between the L1 caches and l2_cache_control.

Verification
REQ-035 Reset, then i_read=1 with i_address=16'h1230; L2 model responds 3 cycles after request -> l2_read=1 with l2_address=16'h1230 one cycle after the request; i_resp=1 for 1 cycle; RELEASE; d_resp stays 0.
REQ-036 i_read and d_read rise in the same cycle after reset -> I is served first, then D. Held again simultaneously -> next grant is D (round-robin alternates).
REQ-037 d_write=1 with d_address=16'hBEE0 and d_wdata=128'hA5..A5; d_address changes mid-service -> l2_address stays 16'hBEE0 and l2_wdata stays A5..A5 until l2_resp.
REQ-038 Assert reset during SERVE_D -> next cycle l2_write=0, d_resp never pulses, state IDLE; a following lone i_read is granted.
REQ-039 d_read=d_write=1 alone -> no grant, l2 idle. Both sides requesting for 70000 cycles -> conflict_count=16'hFFFF.
REQ-040 l2_resp pulsed in IDLE -> no resp to either side, no state change.
